// File: rtl/mem_sum_engine.sv
// mem_sum_engine: array-sum co-processor on the shared single-port data memory.
// Reads a length word at base_addr, then that many consecutive words, and
// writes their 16-bit wrapped sum to dest_addr. Carry-outs are kept in ovf.
module mem_sum_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  typedef enum logic [2:0] {IDLE, RD_CNT, RD_ELEM, WR_RES, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, dst;
  logic [DATA_W-1:0] cnt, acc;
  logic [DATA_W:0]   acc_add;

  // Extra top bit captures the carry-out of each accumulation step.
  assign acc_add   = {1'b0, acc} + {1'b0, mem_rdata};
  // Write data is always the accumulator; only meaningful while mem_wr is high.
  assign mem_wdata = acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and bus/status decode; outputs depend only on registered state.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wr    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RD_CNT;
      end
      RD_CNT: begin
        mem_addr  = ptr;
        // A zero-length array skips straight to writing the (zero) result.
        state_nxt = (mem_rdata == '0) ? WR_RES : RD_ELEM;
      end
      RD_ELEM: begin
        mem_addr = ptr;
        if (cnt == DATA_W'(1)) state_nxt = WR_RES;
      end
      WR_RES: begin
        mem_addr  = dst;
        mem_wr    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: pointer walk, element count, accumulation and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      dst <= '0;
      cnt <= '0;
      acc <= '0;
      sum <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ptr <= base_addr;
          dst <= dest_addr;
          acc <= '0;
          ovf <= 1'b0;
        end
        RD_CNT: begin
          cnt <= mem_rdata;
          ptr <= ptr + ADDR_W'(1);
        end
        RD_ELEM: begin
          acc <= acc_add[DATA_W-1:0];
          ovf <= ovf | acc_add[DATA_W];
          ptr <= ptr + ADDR_W'(1);
          cnt <= cnt - DATA_W'(1);
        end
        WR_RES: sum <= acc;
        default: ;
      endcase
    end
  end

endmodule
